fork_arbiter: RTL and testbench

FORK_ARBITER -- requirements
Module: fork_arbiter

---
 rtl/fork_arbiter.sv | 129 ++++++++++++
 tb/tb_fork_arbiter.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/fork_arbiter.sv
// Dining-philosophers fork arbiter: N philosophers on a ring, each needs both
// neighbouring forks to eat; a rotating-pointer scan picks non-conflicting waiters.

module fork_phil #(
  parameter int MAX_EAT    = 4,
  parameter int STARVE_LIM = 16
) (
  input  logic clock,
  input  logic reset_n,
  input  logic req,
  input  logic done,
  input  logic sel,
  output logic eat,
  output logic waiting,
  output logic eat_nxt,
  output logic starve
);
  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, EAT = 2'd2} st_e;

  st_e        st, nxt;
  logic [7:0] meal_cnt, wait_cnt, wait_nxt;

  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) st <= IDLE;
    else          st <= nxt;

  always_comb begin
    nxt = st;
    case (st)
      IDLE: if (req) nxt = WAIT;
      WAIT: if (!req) nxt = IDLE;
            else if (sel) nxt = EAT;
      EAT:  if (done || meal_cnt == 8'(MAX_EAT - 1)) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_comb begin
    eat      = (st == EAT);
    waiting  = (st == WAIT);
    eat_nxt  = (nxt == EAT);
    // k-th cycle spent in WAIT shows wait_cnt == k, saturating
    wait_nxt = (nxt == WAIT) ? ((wait_cnt == 8'hFF) ? 8'hFF : wait_cnt + 8'd1) : 8'd0;
  end

  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      meal_cnt <= '0;
      wait_cnt <= '0;
      starve   <= 1'b0;
    end else begin
      meal_cnt <= (st == EAT) ? meal_cnt + 8'd1 : 8'd0;
      wait_cnt <= wait_nxt;
      starve   <= (wait_nxt >= 8'(STARVE_LIM));
    end
endmodule

module fork_arbiter #(
  parameter int N          = 8,
  parameter int MAX_EAT    = 4,
  parameter int STARVE_LIM = 16
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic [N-1:0] req,
  input  logic [N-1:0] done,
  output logic [N-1:0] grant,
  output logic [N-1:0] starve,
  output logic [5:0]   eat_cnt
);
  localparam int PW = $clog2(N);

  logic [N-1:0]  wait_v, eat_nxt, sel;
  logic [PW-1:0] ptr, ptr_nxt;
  logic [5:0]    pc;

  fork_phil #(.MAX_EAT(MAX_EAT), .STARVE_LIM(STARVE_LIM)) u_phil [N-1:0] (
    .clock   (clock),
    .reset_n (reset_n),
    .req     (req),
    .done    (done),
    .sel     (sel),
    .eat     (grant),
    .waiting (wait_v),
    .eat_nxt (eat_nxt),
    .starve  (starve)
  );

  // Greedy ring scan from ptr; a neighbour still in EAT (even one releasing
  // this edge) or already picked earlier in the scan blocks selection.
  always_comb begin
    logic [N-1:0]  s;
    logic [PW-1:0] idx, lft, rgt;
    logic          any;
    int            last;
    s    = '0;
    any  = 1'b0;
    last = 0;
    idx  = '0;
    lft  = '0;
    rgt  = '0;
    for (int k = 0; k < N; k++) begin
      idx = PW'((int'(ptr) + k) % N);
      lft = PW'((int'(idx) + N - 1) % N);
      rgt = PW'((int'(idx) + 1) % N);
      if (wait_v[idx] && req[idx] && !grant[lft] && !grant[rgt] && !s[lft] && !s[rgt]) begin
        s[idx] = 1'b1;
        any    = 1'b1;
        last   = int'(idx);
      end
    end
    sel     = s;
    ptr_nxt = any ? PW'((last + 1) % N) : ptr;
  end

  always_comb begin
    pc = '0;
    for (int i = 0; i < N; i++) pc = pc + {5'd0, eat_nxt[i]};
  end

  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      ptr     <= '0;
      eat_cnt <= '0;
    end else begin
      ptr     <= ptr_nxt;
      eat_cnt <= pc;
    end
endmodule

// File: tb/tb_fork_arbiter.sv
// Directed scoreboard bench for fork_arbiter (N=8, MAX_EAT=4, STARVE_LIM=16):
// stimulus rows push expected outputs, a negedge monitor pops and compares.

module tb_fork_arbiter;
  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] req = '0, done = '0;
  logic [7:0] grant, starve;
  logic [5:0] eat_cnt;

  int checks = 0, failures = 0;

  typedef struct {
    logic [7:0] g;
    logic [5:0] e;
    logic [7:0] s;
    string      nm;
  } exp_t;

  exp_t q[$];

  fork_arbiter #(.N(8), .MAX_EAT(4), .STARVE_LIM(16)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .req     (req),
    .done    (done),
    .grant   (grant),
    .starve  (starve),
    .eat_cnt (eat_cnt)
  );

  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // monitor: ring exclusion every cycle, plus scoreboard entries as they arrive
  always @(negedge clock) begin
    if (reset_n) chk("adjacent_grant", 32'(grant & {grant[0], grant[7:1]}), 32'd0);
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk({e.nm, ".grant"},   32'(grant),   32'(e.g));
      chk({e.nm, ".eat_cnt"}, 32'(eat_cnt), 32'(e.e));
      chk({e.nm, ".starve"},  32'(starve),  32'(e.s));
    end
  end

  // one row: inputs seen at the next edge, expected outputs just after it
  task automatic cyc(input logic [7:0] r, input logic [7:0] d, input logic [7:0] g,
                     input logic [5:0] e, input logic [7:0] s, input string nm);
    req  = r;
    done = d;
    @(posedge clock);
    #1;
    q.push_back('{g, e, s, nm});
  endtask

  // asynchronous reset mid-cycle; outputs must clear before any edge
  task automatic do_reset(input string nm);
    @(negedge clock);
    #2;
    reset_n = 1'b0;
    #1;
    chk({nm, ".rst_grant"},   32'(grant),   32'd0);
    chk({nm, ".rst_eat_cnt"}, 32'(eat_cnt), 32'd0);
    chk({nm, ".rst_starve"},  32'(starve),  32'd0);
    req  = '0;
    done = '0;
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    // single philosopher: 2-edge latency, 4-cycle forced release, re-request
    do_reset("A");
    cyc(8'h01, 8'h00, 8'h00, 6'd0, 8'h00, "A1");
    cyc(8'h01, 8'h00, 8'h01, 6'd1, 8'h00, "A2");
    cyc(8'h01, 8'h00, 8'h01, 6'd1, 8'h00, "A3");
    cyc(8'h01, 8'h00, 8'h01, 6'd1, 8'h00, "A4");
    cyc(8'h01, 8'h00, 8'h01, 6'd1, 8'h00, "A5");
    cyc(8'h01, 8'h00, 8'h00, 6'd0, 8'h00, "A6");
    cyc(8'h01, 8'h00, 8'h00, 6'd0, 8'h00, "A7");
    cyc(8'h01, 8'h00, 8'h01, 6'd1, 8'h00, "A8");

    // everyone hungry: evens then odds alternate, 7/0 never together
    do_reset("B");
    cyc(8'hFF, 8'h00, 8'h00, 6'd0, 8'h00, "B1");
    for (int k = 2; k <= 17; k++) begin
      int ph;
      ph = (k - 2) % 5;
      if (ph == 4)            cyc(8'hFF, 8'h00, 8'h00, 6'd0, 8'h00, $sformatf("B%0d", k));
      else if (((k - 2) / 5) % 2 == 0)
                              cyc(8'hFF, 8'h00, 8'h55, 6'd4, 8'h00, $sformatf("B%0d", k));
      else                    cyc(8'hFF, 8'h00, 8'hAA, 6'd4, 8'h00, $sformatf("B%0d", k));
    end

    // done pulse releases 1; waiting neighbour 2 only gets forks one edge later
    do_reset("C");
    cyc(8'h02, 8'h02, 8'h00, 6'd0, 8'h00, "C1");
    cyc(8'h02, 8'h00, 8'h02, 6'd1, 8'h00, "C2");
    cyc(8'h06, 8'h00, 8'h02, 6'd1, 8'h00, "C3");
    cyc(8'h06, 8'h02, 8'h00, 6'd0, 8'h00, "C4");
    cyc(8'h06, 8'h00, 8'h04, 6'd1, 8'h00, "C5");
    cyc(8'h06, 8'h02, 8'h04, 6'd1, 8'h00, "C6");
    cyc(8'h02, 8'h00, 8'h04, 6'd1, 8'h00, "C7");
    cyc(8'h02, 8'h00, 8'h04, 6'd1, 8'h00, "C8");
    cyc(8'h02, 8'h00, 8'h00, 6'd0, 8'h00, "C9");
    cyc(8'h02, 8'h00, 8'h02, 6'd1, 8'h00, "C10");

    // 2 and 4 keep 3 blocked; starve[3] at 16th wait cycle, clears on grant
    do_reset("D");
    cyc(8'h0C, 8'h00, 8'h00, 6'd0, 8'h00, "D1");
    cyc(8'h0C, 8'h00, 8'h04, 6'd1, 8'h00, "D2");
    cyc(8'h1C, 8'h00, 8'h04, 6'd1, 8'h00, "D3");
    cyc(8'h1C, 8'h00, 8'h14, 6'd2, 8'h00, "D4");
    cyc(8'h1C, 8'h00, 8'h14, 6'd2, 8'h00, "D5");
    cyc(8'h1C, 8'h00, 8'h10, 6'd1, 8'h00, "D6");
    cyc(8'h1C, 8'h00, 8'h10, 6'd1, 8'h00, "D7");
    cyc(8'h1C, 8'h00, 8'h04, 6'd1, 8'h00, "D8");
    cyc(8'h1C, 8'h00, 8'h04, 6'd1, 8'h00, "D9");
    cyc(8'h1C, 8'h00, 8'h14, 6'd2, 8'h00, "D10");
    cyc(8'h1C, 8'h00, 8'h14, 6'd2, 8'h00, "D11");
    cyc(8'h1C, 8'h00, 8'h10, 6'd1, 8'h00, "D12");
    cyc(8'h1C, 8'h00, 8'h10, 6'd1, 8'h00, "D13");
    cyc(8'h1C, 8'h00, 8'h04, 6'd1, 8'h00, "D14");
    cyc(8'h1C, 8'h00, 8'h04, 6'd1, 8'h00, "D15");
    cyc(8'h1C, 8'h00, 8'h14, 6'd2, 8'h08, "D16");
    cyc(8'h08, 8'h00, 8'h14, 6'd2, 8'h08, "D17");
    cyc(8'h08, 8'h00, 8'h10, 6'd1, 8'h08, "D18");
    cyc(8'h08, 8'h00, 8'h10, 6'd1, 8'h08, "D19");
    cyc(8'h08, 8'h00, 8'h00, 6'd0, 8'h08, "D20");
    cyc(8'h08, 8'h00, 8'h08, 6'd1, 8'h00, "D21");
    cyc(8'h08, 8'h00, 8'h08, 6'd1, 8'h00, "D22");

    // withdrawal before grant: no pulse, fresh request starts over
    do_reset("E");
    cyc(8'h20, 8'h00, 8'h00, 6'd0, 8'h00, "E1");
    cyc(8'h00, 8'h00, 8'h00, 6'd0, 8'h00, "E2");
    cyc(8'h00, 8'h00, 8'h00, 6'd0, 8'h00, "E3");
    cyc(8'h20, 8'h00, 8'h00, 6'd0, 8'h00, "E4");
    cyc(8'h20, 8'h00, 8'h20, 6'd1, 8'h00, "E5");

    // reset while grant=11, then normal arbitration again
    do_reset("F");
    cyc(8'h11, 8'h00, 8'h00, 6'd0, 8'h00, "F1");
    cyc(8'h11, 8'h00, 8'h11, 6'd2, 8'h00, "F2");
    do_reset("F_mid");
    cyc(8'h11, 8'h00, 8'h00, 6'd0, 8'h00, "F3");
    cyc(8'h11, 8'h00, 8'h11, 6'd2, 8'h00, "F4");
    cyc(8'h11, 8'h00, 8'h11, 6'd2, 8'h00, "F5");

    @(negedge clock);
    #1;
    chk("scoreboard_drained", 32'(q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
